param_issue_queue: RTL and testbench
====================================

PARAM_ISSUE_QUEUE -- requirements
Module: param_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries (>=2).
REQ-002 SHALL have parameter DATA_W, default 32, operand width.
REQ-003 SHALL have parameter TAG_W, default 5, producer-tag width; tag 0 means operand ready.
REQ-004 SHALL have parameter OP_W, default 2, opcode width.
REQ-005 SHALL have parameter ID_BASE, default 1, first entry ID; IDs are ID_BASE..ID_BASE+DEPTH-1, never 0.
REQ-006 SHALL have ports: clk in 1, rising-edge clock; nRST in 1, asynchronous active-low reset.
REQ-007 SHALL have ports: flush in 1, synchronous clear; in_valid in 1; in_ready out 1.
REQ-008 SHALL have ports: in_op in OP_W; in_a, in_b in DATA_W; in_a_tag, in_b_tag in TAG_W.
REQ-009 SHALL have port alloc_id out TAG_W, ID given to the entry pushed this cycle.
REQ-010 SHALL have ports: bc_en in 1; bc_tag in TAG_W; bc_data in DATA_W (result broadcast).
REQ-011 SHALL have ports: out_valid out 1; out_ready in 1; out_op out OP_W; out_a, out_b out DATA_W; out_id out TAG_W.
REQ-012 SHALL have ports: count out $clog2(DEPTH+1); full out 1; empty out 1.

Function
REQ-013 Entries SHALL be held in order, slot 0 = head (oldest); valid slots contiguous from 0.
REQ-014 push = in_valid && in_ready; pop = out_valid && out_ready; both act at the rising edge.
REQ-015 in_ready SHALL be !flush && (!full || pop), combinational.
REQ-016 out_valid SHALL be 1 iff slot 0 valid and both its stored tags are 0; out_op/out_a/out_b/out_id SHALL show slot 0 directly.
REQ-017 A broadcast SHALL NOT bypass to out_*; an entry made ready by a broadcast SHALL be issuable the next cycle.
REQ-018 Snoop: when bc_en && bc_tag != 0, every valid stored operand whose tag equals bc_tag SHALL capture bc_data and clear its tag to 0 at the edge.
REQ-019 Snoop SHALL also apply to the pushed operands (in_x_tag == bc_tag -> store bc_data, tag 0) and to entries moving during a pop shift.
REQ-020 bc_en with bc_tag == 0 SHALL be ignored.
REQ-021 Push without pop SHALL write slot count; count increments.
REQ-022 Pop without push SHALL shift slot i+1 to slot i for all i, clear the last valid slot; count decrements.
REQ-023 Push with pop SHALL shift and write the new entry at slot count-1; count unchanged.
REQ-024 alloc_id SHALL be the lowest ID not held by any valid entry; when full and pop, alloc_id SHALL equal the head's out_id (reused).
REQ-025 IDs of valid entries SHALL always be pairwise distinct.
REQ-026 full = (count == DEPTH); empty = (count == 0).
REQ-027 flush SHALL clear all entries and count at the edge, with priority over push, pop and snoop.
REQ-028 pop asserted while out_valid is 0 SHALL have no effect.

Reset
REQ-029 nRST low SHALL immediately clear all entries, tags, data, IDs and count, independent of clk.
REQ-030 During reset: out_valid 0, out_op/out_a/out_b/out_id 0, count 0, empty 1, full 0, in_ready 1 (if flush low), alloc_id ID_BASE.
REQ-031 Reset asserted mid-operation SHALL drop all pending entries; no partial state SHALL survive.

Verification
REQ-032 Fill/drain: push 4 ready entries (tags 0, a=1..4), out_ready 0 -> full 1, in_ready 0, IDs 1,2,3,4; then out_ready 1 -> issue a=1,2,3,4 in 4 cycles, then empty 1.
REQ-033 Snoop stored: push a_tag=7; next cycle bc_en, bc_tag=7, bc_data=0xAB -> out_valid 0 that cycle, out_valid 1 next with out_a=0xAB.
REQ-034 Snoop on push: push a_tag=9 with bc_tag=9, bc_data=0x55 same cycle -> entry stored ready, out_valid 1 next cycle, out_a=0x55.
REQ-035 Full push+pop: full with IDs 1..4, head ready, push and pop same edge -> count stays 4, new entry at slot 3 with ID 1, order preserved.
REQ-036 Head blocking: head a_tag=3 unready, slot 1 ready -> out_valid 0, nothing issues until tag 3 broadcast.
REQ-037 Flush/reset: 3 entries, flush with in_valid 1 -> count 0, pushed entry dropped; async nRST low mid-clock -> outputs reach REQ-030 values without a clock edge.

Source files
------------

// File: rtl/param_issue_queue_if.sv
// Issue-queue port bundle: push side, result broadcast, issue side and status.
// Latency: none (wires only).
// Backpressure: in_ready / out_ready carry the valid-ready handshakes.
//
// Ports (as seen by the queue through the slave modport):
//   flush                         in   synchronous clear
//   in_valid/in_ready             push handshake
//   in_op, in_a, in_b             pushed opcode and operands
//   in_a_tag, in_b_tag            producer tags of the pushed operands (0 = ready)
//   alloc_id                      out  ID handed to the entry pushed this cycle
//   bc_en, bc_tag, bc_data        in   result broadcast
//   out_valid/out_ready           issue handshake
//   out_op, out_a, out_b, out_id  out  head entry contents
//   count, full, empty            out  occupancy status
interface param_issue_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int OP_W   = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [TAG_W-1:0]  in_a_tag;
  logic [TAG_W-1:0]  in_b_tag;
  logic [TAG_W-1:0]  alloc_id;

  logic              bc_en;
  logic [TAG_W-1:0]  bc_tag;
  logic [DATA_W-1:0] bc_data;

  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   out_op;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [TAG_W-1:0]  out_id;

  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  // Producer/consumer side: drives pushes, broadcasts and issue acceptance.
  modport master (
    output flush, in_valid, in_op, in_a, in_b, in_a_tag, in_b_tag,
    input  in_ready, alloc_id,
    output bc_en, bc_tag, bc_data,
    input  out_valid, out_op, out_a, out_b, out_id,
    output out_ready,
    input  count, full, empty
  );

  // Queue side.
  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, in_a_tag, in_b_tag,
    output in_ready, alloc_id,
    input  bc_en, bc_tag, bc_data,
    output out_valid, out_op, out_a, out_b, out_id,
    input  out_ready,
    output count, full, empty
  );
endinterface

// File: rtl/param_issue_queue.sv
// In-order issue queue with operand snooping: entries wait at the head until both tags clear.
// Latency: push-to-issue 1 cycle for ready operands; broadcast-to-issue 1 cycle (no bypass).
// Backpressure: in_ready drops when full unless the head issues this cycle; head blocks younger entries.
//
// Ports:
//   clk   in  rising-edge clock
//   nRST  in  asynchronous active-low reset, clears every entry immediately
//   bus   param_issue_queue_if.slave -- push, broadcast, issue and status signals
module param_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 5,
  parameter int OP_W    = 2,
  parameter int ID_BASE = 1
) (
  input  logic                 clk,
  input  logic                 nRST,
  param_issue_queue_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Slot storage; slot 0 is the head (oldest), valid slots are contiguous from 0.
  logic              slotVld  [DEPTH];
  logic [OP_W-1:0]   slotOp   [DEPTH];
  logic [DATA_W-1:0] slotA    [DEPTH];
  logic [DATA_W-1:0] slotB    [DEPTH];
  logic [TAG_W-1:0]  slotATag [DEPTH];
  logic [TAG_W-1:0]  slotBTag [DEPTH];
  logic [TAG_W-1:0]  slotId   [DEPTH];
  logic [CNT_W-1:0]  count;

  logic              nxtVld  [DEPTH];
  logic [OP_W-1:0]   nxtOp   [DEPTH];
  logic [DATA_W-1:0] nxtA    [DEPTH];
  logic [DATA_W-1:0] nxtB    [DEPTH];
  logic [TAG_W-1:0]  nxtATag [DEPTH];
  logic [TAG_W-1:0]  nxtBTag [DEPTH];
  logic [TAG_W-1:0]  nxtId   [DEPTH];
  logic [CNT_W-1:0]  nxtCount;

  logic              isFull;
  logic              isEmpty;
  logic              headReady;
  logic              popEn;
  logic              pushEn;
  logic              snoopEn;
  logic [CNT_W-1:0]  wrIdx;
  logic [TAG_W-1:0]  allocId;

  // Pushed operands after same-cycle snoop.
  logic              pushAHit;
  logic              pushBHit;
  logic [DATA_W-1:0] pushA;
  logic [DATA_W-1:0] pushB;
  logic [TAG_W-1:0]  pushATag;
  logic [TAG_W-1:0]  pushBTag;

  // ---------------------------------------------------------------------------
  // Handshakes and status
  // ---------------------------------------------------------------------------
  assign isFull    = (count == CNT_W'(DEPTH));
  assign isEmpty   = (count == '0);
  assign headReady = slotVld[0] && (slotATag[0] == '0) && (slotBTag[0] == '0);
  assign popEn     = headReady && bus.out_ready;
  // A full queue still accepts when the head leaves on the same edge.
  assign bus.in_ready = !bus.flush && (!isFull || popEn);
  assign pushEn    = bus.in_valid && bus.in_ready;
  // Tag 0 means "already ready", so a zero-tag broadcast must never match.
  assign snoopEn   = bus.bc_en && (bus.bc_tag != '0);
  // On push+pop the shift frees slot count-1, which becomes the tail.
  assign wrIdx     = popEn ? (count - CNT_W'(1)) : count;

  assign bus.out_valid = headReady;
  assign bus.out_op    = slotOp[0];
  assign bus.out_a     = slotA[0];
  assign bus.out_b     = slotB[0];
  assign bus.out_id    = slotId[0];
  assign bus.count     = count;
  assign bus.full      = isFull;
  assign bus.empty     = isEmpty;
  assign bus.alloc_id  = allocId;

  // ---------------------------------------------------------------------------
  // ID allocation: lowest ID not held by a valid entry. When every ID is in use
  // the only legal push is alongside a pop, so the head's ID is recycled.
  // ---------------------------------------------------------------------------
  always_comb begin : allocSel
    logic [DEPTH-1:0] idUsed;
    idUsed = '0;
    for (int k = 0; k < DEPTH; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slotVld[i] && (slotId[i] == TAG_W'(ID_BASE + k))) begin
          idUsed[k] = 1'b1;
        end
      end
    end
    allocId = slotId[0];
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (!idUsed[k]) begin
        allocId = TAG_W'(ID_BASE + k);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pushed operand snoop: a result broadcast in the push cycle is captured
  // directly so the entry is never left waiting on a tag that already fired.
  // ---------------------------------------------------------------------------
  always_comb begin
    pushAHit = snoopEn && (bus.in_a_tag == bus.bc_tag);
    pushBHit = snoopEn && (bus.in_b_tag == bus.bc_tag);
    pushA    = pushAHit ? bus.bc_data : bus.in_a;
    pushB    = pushBHit ? bus.bc_data : bus.in_b;
    pushATag = pushAHit ? '0 : bus.in_a_tag;
    pushBTag = pushBHit ? '0 : bus.in_b_tag;
  end

  // ---------------------------------------------------------------------------
  // Next-state: shift on pop, snoop every surviving entry, write the tail,
  // then let flush override everything.
  // ---------------------------------------------------------------------------
  always_comb begin
    nxtVld   = slotVld;
    nxtOp    = slotOp;
    nxtA     = slotA;
    nxtB     = slotB;
    nxtATag  = slotATag;
    nxtBTag  = slotBTag;
    nxtId    = slotId;
    nxtCount = count;

    if (popEn) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        nxtVld[i]  = slotVld[i+1];
        nxtOp[i]   = slotOp[i+1];
        nxtA[i]    = slotA[i+1];
        nxtB[i]    = slotB[i+1];
        nxtATag[i] = slotATag[i+1];
        nxtBTag[i] = slotBTag[i+1];
        nxtId[i]   = slotId[i+1];
      end
      nxtVld[DEPTH-1]  = 1'b0;
      nxtOp[DEPTH-1]   = '0;
      nxtA[DEPTH-1]    = '0;
      nxtB[DEPTH-1]    = '0;
      nxtATag[DEPTH-1] = '0;
      nxtBTag[DEPTH-1] = '0;
      nxtId[DEPTH-1]   = '0;
    end

    // Applied after the shift so entries moving down still catch the result.
    if (snoopEn) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (nxtVld[i] && (nxtATag[i] == bus.bc_tag)) begin
          nxtA[i]    = bus.bc_data;
          nxtATag[i] = '0;
        end
        if (nxtVld[i] && (nxtBTag[i] == bus.bc_tag)) begin
          nxtB[i]    = bus.bc_data;
          nxtBTag[i] = '0;
        end
      end
    end

    if (pushEn) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == wrIdx) begin
          nxtVld[i]  = 1'b1;
          nxtOp[i]   = bus.in_op;
          nxtA[i]    = pushA;
          nxtB[i]    = pushB;
          nxtATag[i] = pushATag;
          nxtBTag[i] = pushBTag;
          nxtId[i]   = allocId;
        end
      end
    end

    if (pushEn && !popEn) begin
      nxtCount = count + CNT_W'(1);
    end else if (popEn && !pushEn) begin
      nxtCount = count - CNT_W'(1);
    end

    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        nxtVld[i]  = 1'b0;
        nxtOp[i]   = '0;
        nxtA[i]    = '0;
        nxtB[i]    = '0;
        nxtATag[i] = '0;
        nxtBTag[i] = '0;
        nxtId[i]   = '0;
      end
      nxtCount = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        slotVld[i]  <= 1'b0;
        slotOp[i]   <= '0;
        slotA[i]    <= '0;
        slotB[i]    <= '0;
        slotATag[i] <= '0;
        slotBTag[i] <= '0;
        slotId[i]   <= '0;
      end
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slotVld[i]  <= nxtVld[i];
        slotOp[i]   <= nxtOp[i];
        slotA[i]    <= nxtA[i];
        slotB[i]    <= nxtB[i];
        slotATag[i] <= nxtATag[i];
        slotBTag[i] <= nxtBTag[i];
        slotId[i]   <= nxtId[i];
      end
      count <= nxtCount;
    end
  end

  // ---------------------------------------------------------------------------
  // Structural invariants: unique IDs, contiguous valid slots, count agrees
  // with the number of valid slots.
  // ---------------------------------------------------------------------------
  logic             idClash;
  logic             holeFound;
  logic [CNT_W-1:0] vldTally;

  always_comb begin
    idClash   = 1'b0;
    holeFound = 1'b0;
    vldTally  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slotVld[i]) begin
        vldTally = vldTally + CNT_W'(1);
      end
      for (int j = i + 1; j < DEPTH; j++) begin
        if (slotVld[i] && slotVld[j] && (slotId[i] == slotId[j])) begin
          idClash = 1'b1;
        end
      end
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (slotVld[i] && !slotVld[i-1]) begin
        holeFound = 1'b1;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!nRST) !idClash);
  assert property (@(posedge clk) disable iff (!nRST) !holeFound);
  assert property (@(posedge clk) disable iff (!nRST) vldTally == count);

endmodule

// File: tb/tb_param_issue_queue.sv
module tb_param_issue_queue;
  localparam int DEPTH   = 4;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 5;
  localparam int OP_W    = 2;
  localparam int ID_BASE = 1;

  logic clk = 1'b0;
  logic nRST;
  always #5 clk = ~clk;

  param_issue_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) bus ();

  param_issue_queue #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .ID_BASE(ID_BASE)
  ) dut (
    .clk (clk),
    .nRST(nRST),
    .bus (bus)
  );

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  id;
  } sb_t;

  typedef struct {
    bit                inV;
    logic [DATA_W-1:0] a;
    bit                oRdy;
    int                eCount;
    bit                eFull;
    bit                eEmpty;
    bit                eInRdy;
    bit                eOutV;
    int                eAlloc;   // -1: not checked
  } vec_t;

  sb_t sbQ[$];
  int  heldIds[$];
  int  passCnt  = 0;
  int  totalCnt = 0;
  logic [DATA_W-1:0] expA;
  logic [DATA_W-1:0] expB;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // Reference ID allocation over the ordered list of IDs held in the queue.
  function automatic int modelAlloc(input bit popNow);
    bit used;
    if (heldIds.size() == DEPTH) return popNow ? heldIds[0] : -1;
    for (int k = ID_BASE; k < ID_BASE + DEPTH; k++) begin
      used = 1'b0;
      foreach (heldIds[j]) if (heldIds[j] == k) used = 1'b1;
      if (!used) return k;
    end
    return -1;
  endfunction

  task automatic idle();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_a_tag  = '0;
    bus.in_b_tag  = '0;
    bus.bc_en     = 1'b0;
    bus.bc_tag    = '0;
    bus.bc_data   = '0;
    bus.out_ready = 1'b0;
    expA = '0;
    expB = '0;
  endtask

  task automatic pushReq(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a,
                         input logic [TAG_W-1:0] aTag, input logic [DATA_W-1:0] b,
                         input logic [TAG_W-1:0] bTag);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_a_tag = aTag;
    bus.in_b     = b;
    bus.in_b_tag = bTag;
    expA = a;
    expB = b;
  endtask

  task automatic settle();
    #2;
  endtask

  // Scoreboard step: record the push, compare an issue, then advance one clock.
  task automatic tick();
    bit  doPush;
    bit  doPop;
    int  newId;
    sb_t e;
    doPush = bus.in_valid && bus.in_ready;
    doPop  = bus.out_valid && bus.out_ready;
    newId  = 0;
    if (bus.flush) begin
      sbQ.delete();
      heldIds.delete();
      doPush = 1'b0;
      doPop  = 1'b0;
    end
    if (doPush) begin
      newId = modelAlloc(doPop);
      chk("alloc_id", bus.alloc_id, newId);
    end
    if (doPop) begin
      if (sbQ.size() == 0) begin
        chk("issue_unexpected", bus.out_valid, 0);
      end else begin
        e = sbQ.pop_front();
        chk("out_op", bus.out_op, e.op);
        chk("out_a", bus.out_a, e.a);
        chk("out_b", bus.out_b, e.b);
        chk("out_id", bus.out_id, e.id);
        heldIds.delete(0);
      end
    end
    if (doPush) begin
      e.op = bus.in_op;
      e.a  = expA;
      e.b  = expB;
      e.id = newId[TAG_W-1:0];
      sbQ.push_back(e);
      heldIds.push_back(newId);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Fill 4 ready entries with the issue side stalled, then drain.
    vecs[0]  = '{1'b1, 32'd1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[1]  = '{1'b1, 32'd2, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 2};
    vecs[2]  = '{1'b1, 32'd3, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b1, 3};
    vecs[3]  = '{1'b1, 32'd4, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b1, 4};
    vecs[4]  = '{1'b1, 32'd5, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b1, -1};
    vecs[5]  = '{1'b0, 32'd0, 1'b1, 4, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    vecs[6]  = '{1'b0, 32'd0, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    vecs[7]  = '{1'b0, 32'd0, 1'b1, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    vecs[8]  = '{1'b0, 32'd0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    vecs[9]  = '{1'b0, 32'd0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[10] = '{1'b0, 32'd0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1};

    nRST = 1'b1;
    idle();
    #1 nRST = 1'b0;
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_alloc_id", bus.alloc_id, ID_BASE);
    chk("rst_out_a", bus.out_a, 0);
    chk("rst_out_id", bus.out_id, 0);
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven fill/drain.
    for (int v = 0; v < 11; v++) begin
      idle();
      bus.in_valid  = vecs[v].inV;
      bus.in_a      = vecs[v].a;
      bus.out_ready = vecs[v].oRdy;
      expA = vecs[v].a;
      settle();
      chk($sformatf("vec%0d_count", v), bus.count, vecs[v].eCount);
      chk($sformatf("vec%0d_full", v), bus.full, vecs[v].eFull);
      chk($sformatf("vec%0d_empty", v), bus.empty, vecs[v].eEmpty);
      chk($sformatf("vec%0d_in_ready", v), bus.in_ready, vecs[v].eInRdy);
      chk($sformatf("vec%0d_out_valid", v), bus.out_valid, vecs[v].eOutV);
      if (vecs[v].eAlloc >= 0) chk($sformatf("vec%0d_alloc", v), bus.alloc_id, vecs[v].eAlloc);
      tick();
    end

    // Snoop on a stored entry: both operands wait on tag 7.
    idle(); pushReq(2'd1, 32'h0, 5'd7, 32'h0, 5'd7); expA = 32'hAB; expB = 32'hAB;
    settle(); tick();
    idle(); bus.bc_en = 1'b1; bus.bc_tag = 5'd7; bus.bc_data = 32'hAB; bus.out_ready = 1'b1;
    settle();
    chk("snoop_no_bypass_valid", bus.out_valid, 0);
    chk("snoop_count", bus.count, 1);
    tick();
    idle(); bus.out_ready = 1'b1;
    settle();
    chk("snoop_valid_next", bus.out_valid, 1);
    chk("snoop_out_a", bus.out_a, 32'hAB);
    tick();
    idle(); settle();
    chk("snoop_empty", bus.empty, 1);
    tick();

    // Snoop on the pushed operand in the same cycle.
    idle(); pushReq(2'd2, 32'h0, 5'd9, 32'h66, 5'd0);
    bus.bc_en = 1'b1; bus.bc_tag = 5'd9; bus.bc_data = 32'h55; expA = 32'h55;
    settle(); tick();
    idle(); bus.out_ready = 1'b1;
    settle();
    chk("push_snoop_valid", bus.out_valid, 1);
    chk("push_snoop_out_a", bus.out_a, 32'h55);
    tick();

    // A zero-tag broadcast must not touch ready operands.
    idle(); pushReq(2'd0, 32'h11, 5'd0, 32'h22, 5'd0);
    bus.bc_en = 1'b1; bus.bc_tag = 5'd0; bus.bc_data = 32'hEE;
    settle(); tick();
    idle(); bus.bc_en = 1'b1; bus.bc_tag = 5'd0; bus.bc_data = 32'hEE;
    settle(); tick();
    idle(); bus.out_ready = 1'b1;
    settle();
    chk("tag0_ignored_a", bus.out_a, 32'h11);
    tick();

    // Head blocking: unready head holds back a ready younger entry.
    idle(); pushReq(2'd1, 32'h0, 5'd3, 32'h5, 5'd0); expA = 32'h33;
    settle(); tick();
    idle(); pushReq(2'd2, 32'h44, 5'd0, 32'h6, 5'd0);
    settle(); tick();
    for (int c = 0; c < 2; c++) begin
      idle(); bus.out_ready = 1'b1;
      settle();
      chk($sformatf("block%0d_valid", c), bus.out_valid, 0);
      chk($sformatf("block%0d_count", c), bus.count, 2);
      tick();
    end
    idle(); bus.out_ready = 1'b1; bus.bc_en = 1'b1; bus.bc_tag = 5'd3; bus.bc_data = 32'h33;
    settle();
    chk("block_bc_cycle_valid", bus.out_valid, 0);
    tick();
    idle(); bus.out_ready = 1'b1;
    settle();
    chk("unblock_valid", bus.out_valid, 1);
    tick();
    idle(); bus.out_ready = 1'b1;
    settle();
    chk("second_out_a", bus.out_a, 32'h44);
    tick();
    idle(); settle();
    chk("block_empty", bus.empty, 1);
    tick();

    // Full queue: push and pop on the same edge recycles the head ID.
    for (int i = 0; i < DEPTH; i++) begin
      idle(); pushReq(OP_W'(i), DATA_W'(32'h10 + i), 5'd0, DATA_W'(32'h20 + i), 5'd0);
      settle(); tick();
    end
    idle(); pushReq(2'd3, 32'h99, 5'd0, 32'h98, 5'd0); bus.out_ready = 1'b1;
    settle();
    chk("fullpp_full", bus.full, 1);
    chk("fullpp_in_ready", bus.in_ready, 1);
    chk("fullpp_alloc_reuse", bus.alloc_id, 1);
    tick();
    idle(); settle();
    chk("fullpp_count", bus.count, 4);
    chk("fullpp_new_head_a", bus.out_a, 32'h11);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      idle(); bus.out_ready = 1'b1;
      settle(); tick();
    end
    idle(); settle();
    chk("fullpp_drained", bus.empty, 1);
    tick();

    // Flush beats a simultaneous push.
    for (int i = 0; i < 3; i++) begin
      idle(); pushReq(2'd0, DATA_W'(32'h21 + i), 5'd0, 32'h0, 5'd0);
      settle(); tick();
    end
    idle(); bus.flush = 1'b1; pushReq(2'd0, 32'h77, 5'd0, 32'h0, 5'd0);
    settle();
    chk("flush_in_ready", bus.in_ready, 0);
    tick();
    idle(); settle();
    chk("flush_count", bus.count, 0);
    chk("flush_empty", bus.empty, 1);
    chk("flush_out_valid", bus.out_valid, 0);
    tick();
    idle(); pushReq(2'd1, 32'h88, 5'd0, 32'h0, 5'd0);
    settle(); tick();
    idle(); bus.out_ready = 1'b1;
    settle(); tick();

    // Asynchronous reset in the middle of a clock period.
    for (int i = 0; i < 2; i++) begin
      idle(); pushReq(2'd2, DATA_W'(32'h31 + i), 5'd0, 32'h0, 5'd0);
      settle(); tick();
    end
    idle();
    #2 nRST = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_op", bus.out_op, 0);
    chk("arst_out_a", bus.out_a, 0);
    chk("arst_out_id", bus.out_id, 0);
    chk("arst_count", bus.count, 0);
    chk("arst_empty", bus.empty, 1);
    chk("arst_full", bus.full, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_alloc_id", bus.alloc_id, ID_BASE);
    sbQ.delete();
    heldIds.delete();
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    #1;
    idle(); settle();
    chk("post_rst_count", bus.count, 0);
    tick();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
